mul_rs_dispatch: RTL and testbench

//  Multiply/divide reservation station and dispatcher: initiator side of the mul/div execution-unit interface.

---
 rtl/mul_rs_dispatch.sv | 208 ++++++++++++++++++++
 tb/tb_mul_rs_dispatch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rs_dispatch.sv
// mul_rs_dispatch: mul/div reservation station. It snoops the CDB and dispatches one ready op at a time.
// Define MUL_RS_AGE_EN to dispatch the oldest ready entry instead of the lowest-index ready entry.
module mul_rs_dispatch #(
  parameter int NUM_ENTRIES = 3,
  parameter int DATA_W      = 8,
  parameter int TAG_W       = 3,
  parameter int REG_W       = 4,
  parameter int FUNC_W      = 4
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [FUNC_W-1:0] issue_func,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [TAG_W-1:0]  issue_rob,
  input  logic              issue_r1,
  input  logic [DATA_W-1:0] issue_v1,
  input  logic [TAG_W-1:0]  issue_t1,
  input  logic              issue_r2,
  input  logic [DATA_W-1:0] issue_v2,
  input  logic [TAG_W-1:0]  issue_t2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              ex_b,
  output logic [2:0]        rs_index,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [FUNC_W-1:0] func,
  output logic [TAG_W-1:0]  rob_ind,
  output logic [REG_W-1:0]  rd,
  input  logic              exec_done,
  input  logic [2:0]        exec_idx,
  output logic [2:0]        mul_count
);

  typedef struct packed {
    logic              busy;
    logic              exec;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [TAG_W-1:0]  rob;
    logic              r1;
    logic [DATA_W-1:0] v1;
    logic [TAG_W-1:0]  t1;
    logic              r2;
    logic [DATA_W-1:0] v2;
    logic [TAG_W-1:0]  t2;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  entry_t     ent [NUM_ENTRIES];
  entry_t     new_ent;
  entry_t     sel_ent;
  state_t     state;
  logic       have_free;
  logic       have_ready;
  logic       issue_acc;
  logic       done_acc;
  logic [2:0] free_idx;
  logic [2:0] sel_idx;

  function automatic logic is_ready(entry_t e);
    return e.busy && !e.exec && e.r1 && e.r2;
  endfunction

  // Descending scan so the lowest free index wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!ent[i].busy) begin
        have_free = 1'b1;
        free_idx  = 3'(i);
      end
    end
  end

  assign issue_ready = have_free;
  assign issue_acc   = issue_valid && have_free;
  assign done_acc    = (state == S_WAIT) && exec_done && (exec_idx == rs_index);

  // A new entry captures a same-cycle CDB broadcast for any operand it is still waiting on.
  always_comb begin
    new_ent      = '0;
    new_ent.busy = 1'b1;
    new_ent.func = issue_func;
    new_ent.rd   = issue_rd;
    new_ent.rob  = issue_rob;
    new_ent.t1   = issue_t1;
    new_ent.t2   = issue_t2;
    new_ent.r1   = issue_r1 || (cdb_valid && cdb_tag == issue_t1);
    new_ent.r2   = issue_r2 || (cdb_valid && cdb_tag == issue_t2);
    new_ent.v1   = issue_r1 ? issue_v1 : cdb_data;
    new_ent.v2   = issue_r2 ? issue_v2 : cdb_data;
  end

`ifdef MUL_RS_AGE_EN
  localparam logic [TAG_W-1:0] AGE_MAX = '1;
  logic [TAG_W-1:0] age [NUM_ENTRIES];
  logic [TAG_W-1:0] best_age;

  always_ff @(posedge clk2) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (rst || (issue_acc && free_idx == 3'(i)))
        age[i] <= '0;
      else if (ent[i].busy && age[i] != AGE_MAX)
        age[i] <= age[i] + 1'b1;
    end
  end

  // A strictly-greater compare keeps the lowest index on equal ages.
  always_comb begin
    have_ready = 1'b0;
    sel_idx    = '0;
    sel_ent    = '0;
    best_age   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (is_ready(ent[i]) && (!have_ready || age[i] > best_age)) begin
        have_ready = 1'b1;
        sel_idx    = 3'(i);
        sel_ent    = ent[i];
        best_age   = age[i];
      end
    end
  end
`else
  always_comb begin
    have_ready = 1'b0;
    sel_idx    = '0;
    sel_ent    = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (is_ready(ent[i])) begin
        have_ready = 1'b1;
        sel_idx    = 3'(i);
        sel_ent    = ent[i];
      end
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk2) begin
    if (rst) begin
      // NOTE: only busy/exec are reset; payload fields are don't-care until the entry is loaded.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent[i].busy <= 1'b0;
        ent[i].exec <= 1'b0;
      end
      state     <= S_IDLE;
      ex_b      <= 1'b0;
      rs_index  <= '0;
      rs1_data  <= '0;
      rs2_data  <= '0;
      func      <= '0;
      rob_ind   <= '0;
      rd        <= '0;
      mul_count <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (issue_acc && free_idx == 3'(i)) begin
          ent[i] <= new_ent;
        end else if (done_acc && rs_index == 3'(i)) begin
          ent[i].busy <= 1'b0;
          ent[i].exec <= 1'b0;
        end else begin
          if (state == S_IDLE && have_ready && sel_idx == 3'(i))
            ent[i].exec <= 1'b1;
          if (ent[i].busy && cdb_valid && !ent[i].r1 && ent[i].t1 == cdb_tag) begin
            ent[i].r1 <= 1'b1;
            ent[i].v1 <= cdb_data;
          end
          if (ent[i].busy && cdb_valid && !ent[i].r2 && ent[i].t2 == cdb_tag) begin
            ent[i].r2 <= 1'b1;
            ent[i].v2 <= cdb_data;
          end
        end
      end

      mul_count <= mul_count + 3'(issue_acc) - 3'(done_acc);

      ex_b <= 1'b0;
      case (state)
        S_IDLE: begin
          if (have_ready) begin
            ex_b     <= 1'b1;
            rs_index <= sel_idx;
            rs1_data <= sel_ent.v1;
            rs2_data <= sel_ent.v2;
            func     <= sel_ent.func;
            rob_ind  <= sel_ent.rob;
            rd       <= sel_ent.rd;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done_acc)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_rs_dispatch.sv
// Scoreboard bench for mul_rs_dispatch: stimulus pushes expected dispatches, a negedge monitor pops them.
// Expected dispatch order for the age test follows MUL_RS_AGE_EN.
module tb_mul_rs_dispatch;

  localparam logic [3:0] MUL = 4'b0010;
  localparam logic [3:0] DIV = 4'b0011;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] v1;
    logic [7:0] v2;
    logic [3:0] func;
    logic [2:0] rob;
    logic [3:0] rd;
  } disp_t;

  logic       clk2 = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic       issue_ready;
  logic [3:0] issue_func;
  logic [3:0] issue_rd;
  logic [2:0] issue_rob;
  logic       issue_r1, issue_r2;
  logic [7:0] issue_v1, issue_v2;
  logic [2:0] issue_t1, issue_t2;
  logic       cdb_valid;
  logic [2:0] cdb_tag;
  logic [7:0] cdb_data;
  logic       ex_b;
  logic [2:0] rs_index;
  logic [7:0] rs1_data, rs2_data;
  logic [3:0] func;
  logic [2:0] rob_ind;
  logic [3:0] rd;
  logic       exec_done;
  logic [2:0] exec_idx;
  logic [2:0] mul_count;

  int    checks = 0;
  int    errors = 0;
  disp_t exp_q[$];
  disp_t exp_d, got_d;
  logic  prev_ex_b = 1'b0;
  logic [2:0] first_idx, second_idx;

  mul_rs_dispatch dut (
    .clk2(clk2), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_func(issue_func), .issue_rd(issue_rd), .issue_rob(issue_rob),
    .issue_r1(issue_r1), .issue_v1(issue_v1), .issue_t1(issue_t1),
    .issue_r2(issue_r2), .issue_v2(issue_v2), .issue_t2(issue_t2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_b(ex_b), .rs_index(rs_index), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .func(func), .rob_ind(rob_ind), .rd(rd),
    .exec_done(exec_done), .exec_idx(exec_idx), .mul_count(mul_count)
  );

  always #5 clk2 = ~clk2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic issue_op(input logic [3:0] f, input logic [3:0] d, input logic [2:0] rob,
                          input logic r1, input logic [7:0] v1, input logic [2:0] t1,
                          input logic r2, input logic [7:0] v2, input logic [2:0] t2);
    issue_valid = 1'b1;
    issue_func  = f;   issue_rd = d;   issue_rob = rob;
    issue_r1    = r1;  issue_v1 = v1;  issue_t1  = t1;
    issue_r2    = r2;  issue_v2 = v2;  issue_t2  = t2;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [7:0] data);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
    step();
    cdb_valid = 1'b0;
  endtask

  task automatic done(input logic [2:0] idx);
    exec_done = 1'b1; exec_idx = idx;
    step();
    exec_done = 1'b0;
  endtask

  function automatic disp_t mk(input logic [2:0] idx, input logic [7:0] v1, input logic [7:0] v2,
                               input logic [3:0] f, input logic [2:0] rob, input logic [3:0] d);
    disp_t r;
    r.idx = idx; r.v1 = v1; r.v2 = v2; r.func = f; r.rob = rob; r.rd = d;
    return r;
  endfunction

  // Monitor: every dispatch must be a one-cycle pulse matching the head of the expected queue.
  always @(negedge clk2) begin
    if (ex_b) begin
      check("ex_b_one_cycle", 32'(prev_ex_b), 32'd0);
      got_d = mk(rs_index, rs1_data, rs2_data, func, rob_ind, rd);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dispatch_unexpected: got 0x%0h expected none", got_d);
      end else begin
        exp_d = exp_q.pop_front();
        check("dispatch", 32'(got_d), 32'(exp_d));
      end
    end
    prev_ex_b = ex_b;
  end

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_func = '0; issue_rd = '0; issue_rob = '0;
    issue_r1 = 1'b0; issue_v1 = '0; issue_t1 = '0; issue_r2 = 1'b0; issue_v2 = '0; issue_t2 = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; exec_done = 1'b0; exec_idx = '0;
    step(); step();
    rst = 1'b0;
    check("reset_ex_b", 32'(ex_b), 32'd0);
    check("reset_issue_ready", 32'(issue_ready), 32'd1);
    check("reset_mul_count", 32'(mul_count), 32'd0);
    check("reset_data", 32'({rs_index, rs1_data, rs2_data, func, rob_ind, rd}), 32'd0);

    // T1: reset with one op in flight and one pending; a later exec_done is ignored.
    exp_q.push_back(mk(3'd0, 8'd7, 8'd2, MUL, 3'd1, 4'd1));
    issue_op(MUL, 4'd1, 3'd1, 1'b1, 8'd7, 3'd0, 1'b1, 8'd2, 3'd0);
    issue_op(DIV, 4'd2, 3'd3, 1'b0, 8'd0, 3'd7, 1'b0, 8'd0, 3'd7);
    check("t1_count_before_rst", 32'(mul_count), 32'd2);
    rst = 1'b1; step(); step(); rst = 1'b0;
    check("t1_ex_b", 32'(ex_b), 32'd0);
    check("t1_mul_count", 32'(mul_count), 32'd0);
    check("t1_issue_ready", 32'(issue_ready), 32'd1);
    done(3'd0);
    check("t1_late_done_count", 32'(mul_count), 32'd0);
    step(); step();

    // T2: ready MUL dispatches one cycle after issue; mismatched exec_idx ignored.
    exp_q.push_back(mk(3'd0, 8'd3, 8'd5, MUL, 3'd2, 4'd4));
    issue_op(MUL, 4'd4, 3'd2, 1'b1, 8'd3, 3'd0, 1'b1, 8'd5, 3'd0);
    check("t2_no_dispatch_yet", 32'(ex_b), 32'd0);
    step();
    check("t2_ex_b", 32'(ex_b), 32'd1);
    check("t2_count_busy", 32'(mul_count), 32'd1);
    done(3'd1);
    check("t2_bad_idx_ignored", 32'(mul_count), 32'd1);
    done(3'd0);
    check("t2_count_done", 32'(mul_count), 32'd0);

    // T3: CDB wakeup makes the entry dispatchable one edge later.
    exp_q.push_back(mk(3'd0, 8'd8, 8'd2, DIV, 3'd4, 4'd5));
    issue_op(DIV, 4'd5, 3'd4, 1'b0, 8'd0, 3'd5, 1'b1, 8'd2, 3'd0);
    check("t3_waiting", 32'(ex_b), 32'd0);
    cdb(3'd5, 8'd8);
    check("t3_no_bypass", 32'(ex_b), 32'd0);
    step();
    check("t3_ex_b", 32'(ex_b), 32'd1);
    done(3'd0);

    // T3b: same-cycle issue and CDB broadcast of its pending tag.
    exp_q.push_back(mk(3'd0, 8'h21, 8'd4, MUL, 3'd5, 4'd6));
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 8'h21;
    issue_op(MUL, 4'd6, 3'd5, 1'b0, 8'd0, 3'd3, 1'b1, 8'd4, 3'd0);
    cdb_valid = 1'b0;
    step();
    check("t3b_ex_b", 32'(ex_b), 32'd1);
    done(3'd0);
    check("t3b_count", 32'(mul_count), 32'd0);

    // T5: completion and issue in the same cycle; freed slot reused by the next issue.
    exp_q.push_back(mk(3'd0, 8'd2, 8'd2, MUL, 3'd6, 4'd8));
    issue_op(MUL, 4'd8, 3'd6, 1'b1, 8'd2, 3'd0, 1'b1, 8'd2, 3'd0);
    step();
    check("t5_first_ex_b", 32'(ex_b), 32'd1);
    exec_done = 1'b1; exec_idx = 3'd0;
    issue_op(DIV, 4'd9, 3'd7, 1'b0, 8'd0, 3'd2, 1'b1, 8'd3, 3'd0);
    exec_done = 1'b0;
    check("t5_count_unchanged", 32'(mul_count), 32'd1);
    exp_q.push_back(mk(3'd0, 8'd4, 8'd6, MUL, 3'd0, 4'd10));
    issue_op(MUL, 4'd10, 3'd0, 1'b1, 8'd4, 3'd0, 1'b1, 8'd6, 3'd0);
    step();
    check("t5_reuse_idx", 32'(rs_index), 32'd0);
    check("t5_count_two", 32'(mul_count), 32'd2);
    exp_q.push_back(mk(3'd1, 8'h30, 8'd3, DIV, 3'd7, 4'd9));
    cdb(3'd2, 8'h30);
    done(3'd0);
    step();
    check("t5_second_idx", 32'(rs_index), 32'd1);
    done(3'd1);
    check("t5_count_zero", 32'(mul_count), 32'd0);

    // T4: fill the station with waiting ops; a fourth issue is dropped.
    exp_q.push_back(mk(3'd0, 8'h11, 8'd3, MUL, 3'd1, 4'd1));
    issue_op(MUL, 4'd1, 3'd1, 1'b0, 8'd0, 3'd1, 1'b1, 8'd3, 3'd0);
    issue_op(DIV, 4'd2, 3'd2, 1'b1, 8'h0A, 3'd0, 1'b0, 8'd0, 3'd7);
    issue_op(MUL, 4'd3, 3'd3, 1'b0, 8'd0, 3'd6, 1'b1, 8'd5, 3'd0);
    check("t4_full_ready", 32'(issue_ready), 32'd0);
    check("t4_full_count", 32'(mul_count), 32'd3);
    issue_op(MUL, 4'd9, 3'd7, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    check("t4_dropped_count", 32'(mul_count), 32'd3);
    cdb(3'd1, 8'h11);
    step();
    check("t4_wake_ex_b", 32'(ex_b), 32'd1);
    done(3'd0);
    check("t4_freed_count", 32'(mul_count), 32'd2);
    check("t4_freed_ready", 32'(issue_ready), 32'd1);

    // T6: entry 2 older than entry 0; both woken by the same broadcast.
    issue_op(DIV, 4'd7, 3'd5, 1'b0, 8'd0, 3'd6, 1'b1, 8'd4, 3'd0);
    check("t6_count", 32'(mul_count), 32'd3);
`ifdef MUL_RS_AGE_EN
    first_idx = 3'd2; second_idx = 3'd0;
    exp_q.push_back(mk(3'd2, 8'h66, 8'd5, MUL, 3'd3, 4'd3));
    exp_q.push_back(mk(3'd0, 8'h66, 8'd4, DIV, 3'd5, 4'd7));
`else
    first_idx = 3'd0; second_idx = 3'd2;
    exp_q.push_back(mk(3'd0, 8'h66, 8'd4, DIV, 3'd5, 4'd7));
    exp_q.push_back(mk(3'd2, 8'h66, 8'd5, MUL, 3'd3, 4'd3));
`endif
    cdb(3'd6, 8'h66);
    step();
    check("t6_first_idx", 32'(rs_index), 32'(first_idx));
    done(first_idx);
    step();
    check("t6_second_idx", 32'(rs_index), 32'(second_idx));
    done(second_idx);

    // Entry 1 waits on operand 2.
    exp_q.push_back(mk(3'd1, 8'h0A, 8'h77, DIV, 3'd2, 4'd2));
    cdb(3'd7, 8'h77);
    step();
    done(3'd1);
    check("final_count", 32'(mul_count), 32'd0);
    check("final_ready", 32'(issue_ready), 32'd1);
    step(); step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
